p_iq_sched: RTL and testbench

//  Issue-queue scheduler for one execution pipe (ALU0/ALU1/MDU/LSU), fed by the dispatch stage.

---
 rtl/p_iq_sched.sv | 211 +++++++++++++++++++++
 tb/tb_p_iq_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p_iq_sched.sv
// Issue-queue scheduler for one execution pipe: holds dispatched uops, captures CDB
// wakeups and issues the oldest ready uop through a registered valid/ready port.
module p_iq_sched #(
  parameter  int DEPTH  = 8,
  parameter  int PREG_W = 6,
  parameter  int DATA_W = 32,
  parameter  int CTRL_W = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [1:0]                     enq_valid_i,
  output logic                           enq_ready_o,
  input  logic [1:0][1:0][PREG_W-1:0]    enq_src_preg_i,
  input  logic [1:0][1:0][DATA_W-1:0]    enq_src_data_i,
  input  logic [1:0][1:0]                enq_src_valid_i,
  input  logic [1:0][PREG_W-1:0]         enq_dst_preg_i,
  input  logic [1:0][CTRL_W-1:0]         enq_ctrl_i,
  input  logic [1:0]                     cdb_valid_i,
  input  logic [1:0][PREG_W-1:0]         cdb_preg_i,
  input  logic [1:0][DATA_W-1:0]         cdb_data_i,
  output logic                           issue_valid_o,
  input  logic                           issue_ready_i,
  output logic [1:0][DATA_W-1:0]         issue_data_o,
  output logic [PREG_W-1:0]              issue_dst_preg_o,
  output logic [CTRL_W-1:0]              issue_ctrl_o,
  output logic [CNT_W-1:0]               count_o
);

  logic [DEPTH-1:0]                   valid_r;
  logic [DEPTH-1:0][1:0]              src_valid_r;
  logic [DEPTH-1:0][1:0][PREG_W-1:0]  src_preg_r;
  logic [DEPTH-1:0][1:0][DATA_W-1:0]  src_data_r;
  logic [DEPTH-1:0][PREG_W-1:0]       dst_r;
  logic [DEPTH-1:0][CTRL_W-1:0]       ctrl_r;
  logic [DEPTH-1:0][DEPTH-1:0]        older_r;  // older_r[i][j]: entry i accepted before entry j
  logic [CNT_W-1:0]                   count_r;
  logic                               enq_ready_r;
  logic                               issue_valid_r;
  logic [1:0][DATA_W-1:0]             issue_data_r;
  logic [PREG_W-1:0]                  issue_dst_r;
  logic [CTRL_W-1:0]                  issue_ctrl_r;

  logic [DEPTH-1:0]                   ready_s;
  logic [DEPTH-1:0]                   blocked_s;
  logic [DEPTH-1:0]                   sel_oh_s;
  logic [IDX_W-1:0]                   sel_idx_s;
  logic                               any_ready_s;
  logic                               load_s;
  logic [IDX_W-1:0]                   free0_s;
  logic [IDX_W-1:0]                   free1_s;
  logic [1:0]                         enq_fire_s;
  logic [1:0][IDX_W-1:0]              enq_slot_s;
  logic [CNT_W-1:0]                   count_next_s;
  logic [DEPTH-1:0][1:0][1:0]         res_hit_s;
  logic [1:0][1:0][1:0]               enq_hit_s;

  // Per-CDB-lane match of one source preg; bit 0 is lane0.
  function automatic logic [1:0] cdb_hit(input logic [PREG_W-1:0]      preg,
                                         input logic [1:0]             cv,
                                         input logic [1:0][PREG_W-1:0] cp);
    cdb_hit = {cv[1] & (cp[1] == preg), cv[0] & (cp[0] == preg)};
  endfunction

  // Oldest-ready select: a ready entry is blocked by any older ready entry.
  always_comb begin
    ready_s   = {DEPTH{1'b0}};
    blocked_s = {DEPTH{1'b0}};
    sel_oh_s  = {DEPTH{1'b0}};
    sel_idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i] = valid_r[i] & src_valid_r[i][0] & src_valid_r[i][1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        blocked_s[i] = blocked_s[i] | (ready_s[j] & older_r[j][i]);
      end
      sel_oh_s[i] = ready_s[i] & ~blocked_s[i];
      sel_idx_s   = sel_idx_s | (sel_oh_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    any_ready_s = |ready_s;
    load_s      = any_ready_s & (~issue_valid_r | issue_ready_i);
  end

  // Free-slot search (two lowest unoccupied slots), enqueue steering and next count.
  always_comb begin
    free0_s = {IDX_W{1'b0}};
    free1_s = {IDX_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free1_s = valid_r[i] ? free1_s : free0_s;
      free0_s = valid_r[i] ? free0_s : IDX_W'(i);
    end
    enq_fire_s    = enq_valid_i & {2{enq_ready_r}};
    enq_slot_s[0] = free0_s;
    enq_slot_s[1] = enq_valid_i[0] ? free1_s : free0_s;
    count_next_s  = count_r + CNT_W'(enq_fire_s[0]) + CNT_W'(enq_fire_s[1]) - CNT_W'(load_s);
  end

  // CDB tag compare for resident and incoming operands.
  always_comb begin
    res_hit_s = '0;
    enq_hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int o = 0; o < 2; o++) begin
        res_hit_s[i][o] = cdb_hit(src_preg_r[i][o], cdb_valid_i, cdb_preg_i);
      end
    end
    for (int l = 0; l < 2; l++) begin
      for (int o = 0; o < 2; o++) begin
        enq_hit_s[l][o] = cdb_hit(enq_src_preg_i[l][o], cdb_valid_i, cdb_preg_i);
      end
    end
  end

  // Entry storage: wakeup, free on select, allocate on enqueue, age update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= '0;
      src_valid_r <= '0;
      src_preg_r  <= '0;
      src_data_r  <= '0;
      dst_r       <= '0;
      ctrl_r      <= '0;
      older_r     <= '0;
    end else if (flush_i) begin
      valid_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int o = 0; o < 2; o++) begin
          if (valid_r[i] && !src_valid_r[i][o] && (|res_hit_s[i][o])) begin
            src_valid_r[i][o] <= 1'b1;
            src_data_r[i][o]  <= res_hit_s[i][o][0] ? cdb_data_i[0] : cdb_data_i[1];
          end
        end
      end
      if (load_s) begin
        valid_r[sel_idx_s] <= 1'b0;
      end
      for (int l = 0; l < 2; l++) begin
        if (enq_fire_s[l]) begin
          valid_r[enq_slot_s[l]] <= 1'b1;
          dst_r[enq_slot_s[l]]   <= enq_dst_preg_i[l];
          ctrl_r[enq_slot_s[l]]  <= enq_ctrl_i[l];
          for (int o = 0; o < 2; o++) begin
            src_preg_r[enq_slot_s[l]][o]  <= enq_src_preg_i[l][o];
            src_valid_r[enq_slot_s[l]][o] <= enq_src_valid_i[l][o] | (|enq_hit_s[l][o]);
            src_data_r[enq_slot_s[l]][o]  <= enq_src_valid_i[l][o] ? enq_src_data_i[l][o] :
                                             (enq_hit_s[l][o][0] ? cdb_data_i[0] : cdb_data_i[1]);
          end
          for (int j = 0; j < DEPTH; j++) begin
            older_r[enq_slot_s[l]][j] <= 1'b0;
            older_r[j][enq_slot_s[l]] <= valid_r[j];
          end
        end
      end
      // Paired enqueue: lane0 is older than lane1.
      if (&enq_fire_s) begin
        older_r[enq_slot_s[0]][enq_slot_s[1]] <= 1'b1;
      end
    end
  end

  // Issue register: load on a free/draining slot, clear payload when emptied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_r <= 1'b0;
      issue_data_r  <= '0;
      issue_dst_r   <= {PREG_W{1'b0}};
      issue_ctrl_r  <= {CTRL_W{1'b0}};
    end else if (flush_i) begin
      issue_valid_r <= 1'b0;
      issue_data_r  <= '0;
      issue_dst_r   <= {PREG_W{1'b0}};
      issue_ctrl_r  <= {CTRL_W{1'b0}};
    end else if (load_s) begin
      issue_valid_r <= 1'b1;
      issue_data_r  <= src_data_r[sel_idx_s];
      issue_dst_r   <= dst_r[sel_idx_s];
      issue_ctrl_r  <= ctrl_r[sel_idx_s];
    end else if (issue_ready_i) begin
      issue_valid_r <= 1'b0;
      issue_data_r  <= '0;
      issue_dst_r   <= {PREG_W{1'b0}};
      issue_ctrl_r  <= {CTRL_W{1'b0}};
    end
  end

  // Occupancy and joint enqueue ready, both derived from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= {CNT_W{1'b0}};
      enq_ready_r <= 1'b1;
    end else if (flush_i) begin
      count_r     <= {CNT_W{1'b0}};
      enq_ready_r <= 1'b1;
    end else begin
      count_r     <= count_next_s;
      enq_ready_r <= (count_next_s <= CNT_W'(DEPTH - 2));
    end
  end

  assign enq_ready_o      = enq_ready_r;
  assign issue_valid_o    = issue_valid_r;
  assign issue_data_o     = issue_data_r;
  assign issue_dst_preg_o = issue_dst_r;
  assign issue_ctrl_o     = issue_ctrl_r;
  assign count_o          = count_r;

endmodule

// File: tb/tb_p_iq_sched.sv
// Directed self-checking bench for p_iq_sched: latency, wakeup, full queue,
// age ordering, stall hold, flush and asynchronous reset.
module tb_p_iq_sched;
  localparam int DEPTH  = 8;
  localparam int PREG_W = 6;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        flush_i;
  logic [1:0]                  enq_valid_i;
  logic                        enq_ready_o;
  logic [1:0][1:0][PREG_W-1:0] enq_src_preg_i;
  logic [1:0][1:0][DATA_W-1:0] enq_src_data_i;
  logic [1:0][1:0]             enq_src_valid_i;
  logic [1:0][PREG_W-1:0]      enq_dst_preg_i;
  logic [1:0][CTRL_W-1:0]      enq_ctrl_i;
  logic [1:0]                  cdb_valid_i;
  logic [1:0][PREG_W-1:0]      cdb_preg_i;
  logic [1:0][DATA_W-1:0]      cdb_data_i;
  logic                        issue_valid_o;
  logic                        issue_ready_i;
  logic [1:0][DATA_W-1:0]      issue_data_o;
  logic [PREG_W-1:0]           issue_dst_preg_o;
  logic [CTRL_W-1:0]           issue_ctrl_o;
  logic [CNT_W-1:0]            count_o;

  int n_checks = 0;
  int n_fail   = 0;

  p_iq_sched #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_src_preg_i(enq_src_preg_i), .enq_src_data_i(enq_src_data_i),
    .enq_src_valid_i(enq_src_valid_i), .enq_dst_preg_i(enq_dst_preg_i),
    .enq_ctrl_i(enq_ctrl_i), .cdb_valid_i(cdb_valid_i), .cdb_preg_i(cdb_preg_i),
    .cdb_data_i(cdb_data_i), .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_data_o(issue_data_o), .issue_dst_preg_o(issue_dst_preg_o),
    .issue_ctrl_o(issue_ctrl_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush_i         = 1'b0;
    enq_valid_i     = 2'b00;
    enq_src_preg_i  = '0;
    enq_src_data_i  = '0;
    enq_src_valid_i = '0;
    enq_dst_preg_i  = '0;
    enq_ctrl_i      = '0;
    cdb_valid_i     = 2'b00;
    cdb_preg_i      = '0;
    cdb_data_i      = '0;
  endtask

  // Present one uop on a lane; dst preg is the low bits of ctrl.
  task automatic put(input int l, input logic [5:0] p0, input logic v0, input logic [31:0] d0,
                     input logic [5:0] p1, input logic v1, input logic [31:0] d1,
                     input logic [31:0] ctrl);
    enq_valid_i[l]        = 1'b1;
    enq_src_preg_i[l][0]  = p0;
    enq_src_valid_i[l][0] = v0;
    enq_src_data_i[l][0]  = d0;
    enq_src_preg_i[l][1]  = p1;
    enq_src_valid_i[l][1] = v1;
    enq_src_data_i[l][1]  = d1;
    enq_dst_preg_i[l]     = ctrl[5:0];
    enq_ctrl_i[l]         = ctrl;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_issue_valid got=%b exp=0", issue_valid_o); end
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count_o); end
    n_checks++; if (issue_data_o !== 64'd0) begin n_fail++; $display("FAIL rst_issue_data got=%h exp=0", issue_data_o); end
    n_checks++; if (issue_ctrl_o !== 32'd0) begin n_fail++; $display("FAIL rst_issue_ctrl got=%h exp=0", issue_ctrl_o); end
    rst_n = 1'b1;
    cyc();
    n_checks++; if (enq_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_enq_ready got=%b exp=1", enq_ready_o); end
  endtask

  task automatic test_back_to_back();
    issue_ready_i = 1'b1;
    put(0, 6'd1, 1'b1, 32'hA0, 6'd2, 1'b1, 32'hA1, 32'h0A);
    put(1, 6'd3, 1'b1, 32'hB0, 6'd4, 1'b1, 32'hB1, 32'h0B);
    cyc(); clear_in();
    n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_c1_valid got=%b exp=0", issue_valid_o); end
    n_checks++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL b2b_c1_count got=%0d exp=2", count_o); end
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_c2_valid got=%b exp=1", issue_valid_o); end
    n_checks++; if (issue_ctrl_o !== 32'h0A) begin n_fail++; $display("FAIL b2b_c2_ctrl got=%h exp=0a", issue_ctrl_o); end
    n_checks++; if (issue_data_o[0] !== 32'hA0 || issue_data_o[1] !== 32'hA1) begin n_fail++; $display("FAIL b2b_c2_data got=%h exp=000000a1000000a0", issue_data_o); end
    n_checks++; if (issue_dst_preg_o !== 6'h0A) begin n_fail++; $display("FAIL b2b_c2_dst got=%h exp=0a", issue_dst_preg_o); end
    n_checks++; if (count_o !== 4'd1) begin n_fail++; $display("FAIL b2b_c2_count got=%0d exp=1", count_o); end
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1 || issue_ctrl_o !== 32'h0B) begin n_fail++; $display("FAIL b2b_c3_b got v=%b ctrl=%h exp v=1 ctrl=0b", issue_valid_o, issue_ctrl_o); end
    n_checks++; if (issue_data_o[0] !== 32'hB0) begin n_fail++; $display("FAIL b2b_c3_data got=%h exp=b0", issue_data_o[0]); end
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL b2b_c3_count got=%0d exp=0", count_o); end
    cyc();
    n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_c4_valid got=%b exp=0", issue_valid_o); end
    n_checks++; if (issue_data_o !== 64'd0 || issue_ctrl_o !== 32'd0) begin n_fail++; $display("FAIL b2b_c4_zero got data=%h ctrl=%h exp 0", issue_data_o, issue_ctrl_o); end
  endtask

  task automatic test_wakeup();
    put(0, 6'd5, 1'b0, 32'h0, 6'd6, 1'b1, 32'h66, 32'h15);
    cyc(); clear_in();
    cyc();
    cyc();
    n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL wake_c3_valid got=%b exp=0", issue_valid_o); end
    cdb_valid_i = 2'b01; cdb_preg_i[0] = 6'd5; cdb_data_i[0] = 32'hDEAD;
    cyc(); clear_in();
    n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL wake_c4_valid got=%b exp=0", issue_valid_o); end
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1) begin n_fail++; $display("FAIL wake_c5_valid got=%b exp=1", issue_valid_o); end
    n_checks++; if (issue_data_o[0] !== 32'hDEAD || issue_data_o[1] !== 32'h66) begin n_fail++; $display("FAIL wake_c5_data got=%h exp=00000066 0000dead", issue_data_o); end
    cyc();
    n_checks++; if (issue_valid_o !== 1'b0 || count_o !== 4'd0) begin n_fail++; $display("FAIL wake_drain got v=%b cnt=%0d exp v=0 cnt=0", issue_valid_o, count_o); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      put(0, 6'(10 + 2*k), 1'b0, 32'h0, 6'd60, 1'b1, 32'(256 + 2*k),     32'(2*k));
      put(1, 6'(11 + 2*k), 1'b0, 32'h0, 6'd60, 1'b1, 32'(256 + 2*k + 1), 32'(2*k + 1));
      cyc();
      n_checks++; if (count_o !== 4'(2*k + 2)) begin n_fail++; $display("FAIL fill_count_%0d got=%0d exp=%0d", k, count_o, 2*k + 2); end
      n_checks++; if (enq_ready_o !== (k < 3)) begin n_fail++; $display("FAIL fill_ready_%0d got=%b exp=%b", k, enq_ready_o, k < 3); end
    end
    put(0, 6'd20, 1'b1, 32'h1, 6'd21, 1'b1, 32'h2, 32'h99);
    put(1, 6'd22, 1'b1, 32'h3, 6'd23, 1'b1, 32'h4, 32'h98);
    cyc(); cyc(); clear_in();
    n_checks++; if (count_o !== 4'd8 || enq_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ignore got cnt=%0d rdy=%b exp cnt=8 rdy=0", count_o, enq_ready_o); end
    n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_no_issue got=%b exp=0", issue_valid_o); end
    cdb_valid_i = 2'b11; cdb_preg_i[0] = 6'd13; cdb_preg_i[1] = 6'd13;
    cdb_data_i[0] = 32'hAAAA; cdb_data_i[1] = 32'hBBBB;
    cyc(); clear_in();
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1 || issue_ctrl_o !== 32'd3) begin n_fail++; $display("FAIL full_wake_issue got v=%b ctrl=%h exp v=1 ctrl=3", issue_valid_o, issue_ctrl_o); end
    n_checks++; if (issue_data_o[0] !== 32'hAAAA || issue_data_o[1] !== 32'h103) begin n_fail++; $display("FAIL cdb_lane0_prio got=%h exp=00000103 0000aaaa", issue_data_o); end
    n_checks++; if (count_o !== 4'd7 || enq_ready_o !== 1'b0) begin n_fail++; $display("FAIL count7_ready got cnt=%0d rdy=%b exp cnt=7 rdy=0", count_o, enq_ready_o); end
    flush_i = 1'b1;
    cyc(); clear_in();
  endtask

  task automatic test_age_order();
    put(0, 6'd3, 1'b0, 32'h0,  6'd61, 1'b1, 32'h31, 32'h58);
    put(1, 6'd62, 1'b1, 32'h40, 6'd63, 1'b1, 32'h41, 32'h59);
    cyc(); clear_in();
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1 || issue_ctrl_o !== 32'h59) begin n_fail++; $display("FAIL age_young_first got v=%b ctrl=%h exp v=1 ctrl=59", issue_valid_o, issue_ctrl_o); end
    cdb_valid_i = 2'b10; cdb_preg_i[1] = 6'd3; cdb_data_i[1] = 32'h33;
    cyc(); clear_in();
    n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL age_gap got=%b exp=0", issue_valid_o); end
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1 || issue_ctrl_o !== 32'h58 || issue_data_o[0] !== 32'h33) begin n_fail++; $display("FAIL age_old_next got v=%b ctrl=%h d0=%h exp v=1 ctrl=58 d0=33", issue_valid_o, issue_ctrl_o, issue_data_o[0]); end
    cyc();
    n_checks++; if (issue_valid_o !== 1'b0 || count_o !== 4'd0) begin n_fail++; $display("FAIL age_drain got v=%b cnt=%0d exp v=0 cnt=0", issue_valid_o, count_o); end
  endtask

  task automatic test_stall();
    issue_ready_i = 1'b0;
    put(0, 6'd30, 1'b1, 32'h5000, 6'd31, 1'b1, 32'h5001, 32'h50);
    put(1, 6'd7,  1'b0, 32'h0,    6'd32, 1'b1, 32'h5101, 32'h51);
    cyc(); clear_in();
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1 || issue_ctrl_o !== 32'h50) begin n_fail++; $display("FAIL stall_z_load got v=%b ctrl=%h exp v=1 ctrl=50", issue_valid_o, issue_ctrl_o); end
    put(0, 6'd33, 1'b1, 32'h5200, 6'd34, 1'b1, 32'h5201, 32'h52);
    cdb_valid_i = 2'b01; cdb_preg_i[0] = 6'd7; cdb_data_i[0] = 32'h7777;
    for (int k = 0; k < 4; k++) begin
      cyc(); clear_in();
      n_checks++; if (issue_valid_o !== 1'b1 || issue_ctrl_o !== 32'h50 || issue_data_o[0] !== 32'h5000 || issue_data_o[1] !== 32'h5001 || issue_dst_preg_o !== 6'h10) begin n_fail++; $display("FAIL stall_hold_%0d got v=%b ctrl=%h data=%h dst=%h", k, issue_valid_o, issue_ctrl_o, issue_data_o, issue_dst_preg_o); end
      n_checks++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL stall_count_%0d got=%0d exp=2", k, count_o); end
    end
    issue_ready_i = 1'b1;
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1 || issue_ctrl_o !== 32'h51 || issue_data_o[0] !== 32'h7777) begin n_fail++; $display("FAIL stall_release_old got v=%b ctrl=%h d0=%h exp v=1 ctrl=51 d0=7777", issue_valid_o, issue_ctrl_o, issue_data_o[0]); end
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1 || issue_ctrl_o !== 32'h52) begin n_fail++; $display("FAIL stall_then_young got v=%b ctrl=%h exp v=1 ctrl=52", issue_valid_o, issue_ctrl_o); end
    cyc();
    n_checks++; if (issue_valid_o !== 1'b0 || count_o !== 4'd0) begin n_fail++; $display("FAIL stall_drain got v=%b cnt=%0d exp v=0 cnt=0", issue_valid_o, count_o); end
  endtask

  task automatic test_flush();
    issue_ready_i = 1'b0;
    put(0, 6'd9, 1'b0, 32'h0, 6'd60, 1'b1, 32'h1, 32'hF0);
    put(1, 6'd1, 1'b1, 32'h2, 6'd2,  1'b1, 32'h3, 32'hF1);
    cyc(); clear_in();
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1 || count_o !== 4'd1) begin n_fail++; $display("FAIL flush_setup got v=%b cnt=%0d exp v=1 cnt=1", issue_valid_o, count_o); end
    flush_i = 1'b1;
    put(0, 6'd11, 1'b1, 32'h7, 6'd12, 1'b1, 32'h8, 32'hF2);
    put(1, 6'd13, 1'b1, 32'h9, 6'd14, 1'b1, 32'hA, 32'hF3);
    cdb_valid_i = 2'b01; cdb_preg_i[0] = 6'd9; cdb_data_i[0] = 32'h99;
    cyc(); clear_in();
    issue_ready_i = 1'b1;
    n_checks++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_clear got cnt=%0d v=%b exp cnt=0 v=0", count_o, issue_valid_o); end
    n_checks++; if (issue_data_o !== 64'd0 || issue_ctrl_o !== 32'd0 || enq_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_outs got data=%h ctrl=%h rdy=%b exp 0 0 1", issue_data_o, issue_ctrl_o, enq_ready_o); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++; if (issue_valid_o !== 1'b0 || count_o !== 4'd0) begin n_fail++; $display("FAIL flush_quiet_%0d got v=%b cnt=%0d exp v=0 cnt=0", k, issue_valid_o, count_o); end
    end
  endtask

  task automatic test_async_reset();
    issue_ready_i = 1'b0;
    put(0, 6'd40, 1'b1, 32'h1234, 6'd41, 1'b1, 32'h5678, 32'h77);
    cyc(); clear_in();
    cyc();
    n_checks++; if (issue_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_setup got=%b exp=1", issue_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (issue_valid_o !== 1'b0 || count_o !== 4'd0 || issue_ctrl_o !== 32'd0) begin n_fail++; $display("FAIL arst_immediate got v=%b cnt=%0d ctrl=%h exp 0 0 0", issue_valid_o, count_o, issue_ctrl_o); end
    rst_n = 1'b1;
    cyc();
    n_checks++; if (enq_ready_o !== 1'b1 || issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_after got rdy=%b v=%b exp rdy=1 v=0", enq_ready_o, issue_valid_o); end
  endtask

  initial begin
    clear_in();
    issue_ready_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_wakeup();
    test_fill();
    test_age_order();
    test_stall();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
